mem_bus_ctrl: RTL and testbench

//  Initiator-side memory controller between the RISC-V core's valid/ready memory port and the memories.

---
 rtl/mem_bus_ctrl_if.sv | 19 +
 rtl/mem_bus_ctrl.sv | 126 ++++++++++++
 tb/tb_mem_bus_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_ctrl_if.sv
// Core-side memory port: valid/ready request with byte strobes, single-beat read data return.
interface mem_bus_ctrl_if;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;

   modport master (
      output mem_valid, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Decodes core requests to ROM / RAM / LED / unmapped; ROM, LED and unmapped complete 1 cycle after accept, RAM after 3.
// No request is accepted while one is in flight; mem_ready is a single-cycle pulse and a dropped mem_valid still completes.
module mem_bus_ctrl #(
   parameter int unsigned ROM_WORDS = 256,
   parameter int unsigned RAM_WORDS = 256,
   parameter logic [31:0] RAM_BASE  = 32'h0001_0000,
   parameter logic [31:0] LED_ADDR  = 32'h0002_0000
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   mem_bus_ctrl_if.slave        bus_io,
   output logic [31:0]          rom_addr_o,
   input  logic [31:0]          rom_data_i,
   output logic [3:0]           ram_wen_o,
   output logic [21:0]          ram_addr_o,
   output logic [31:0]          ram_wdata_o,
   input  logic [31:0]          ram_rdata_i,
   output logic [7:0]           leds_o,
   output logic                 bus_err_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RAM_ACC,
      S_RAM_DATA,
      S_DONE
   } state_t;

   // All decoding is done on word addresses, so byte offset bits never affect the target.
   localparam logic [29:0] ROM_LIMIT_W = 30'(ROM_WORDS);
   localparam logic [29:0] RAM_BASE_W  = RAM_BASE[31:2];
   localparam logic [29:0] RAM_END_W   = RAM_BASE[31:2] + 30'(RAM_WORDS);
   localparam logic [29:0] LED_W       = LED_ADDR[31:2];

   state_t      state_q;
   logic        mem_ready_q;
   logic [31:0] mem_rdata_q;
   logic [3:0]  ram_wen_q;
   logic [21:0] ram_addr_q;
   logic [31:0] ram_wdata_q;
   logic [7:0]  leds_q;
   logic        bus_err_q;

   logic [29:0] word_addr;
   logic [21:0] ram_idx;
   logic        rom_hit;
   logic        led_hit;
   logic        ram_hit;
   logic        accept;

   assign word_addr = bus_io.mem_addr[31:2];
   assign ram_idx   = 22'(word_addr - RAM_BASE_W);
   assign rom_hit   = word_addr < ROM_LIMIT_W;
   assign led_hit   = word_addr == LED_W;
   assign ram_hit   = (word_addr >= RAM_BASE_W) && (word_addr < RAM_END_W);
   assign accept    = bus_io.mem_valid && !mem_ready_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         mem_ready_q <= 1'b0;
         mem_rdata_q <= '0;
         ram_wen_q   <= '0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         leds_q      <= '0;
         bus_err_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  if (rom_hit) begin
                     mem_rdata_q <= rom_data_i;
                     mem_ready_q <= 1'b1;
                     state_q     <= S_DONE;
                  end else if (led_hit) begin
                     // Reads return the value held before this access's write.
                     mem_rdata_q <= {24'b0, leds_q};
                     if (bus_io.mem_wstrb[0]) begin
                        leds_q <= bus_io.mem_wdata[7:0];
                     end
                     mem_ready_q <= 1'b1;
                     state_q     <= S_DONE;
                  end else if (ram_hit) begin
                     ram_addr_q  <= ram_idx;
                     ram_wdata_q <= bus_io.mem_wdata;
                     ram_wen_q   <= bus_io.mem_wstrb;
                     state_q     <= S_RAM_ACC;
                  end else begin
                     mem_rdata_q <= '0;
                     bus_err_q   <= 1'b1;
                     mem_ready_q <= 1'b1;
                     state_q     <= S_DONE;
                  end
               end
            end
            S_RAM_ACC: begin
               ram_wen_q <= '0;
               state_q   <= S_RAM_DATA;
            end
            S_RAM_DATA: begin
               mem_rdata_q <= ram_rdata_i;
               mem_ready_q <= 1'b1;
               state_q     <= S_DONE;
            end
            S_DONE: begin
               mem_ready_q <= 1'b0;
               state_q     <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus_io.mem_ready = mem_ready_q;
   assign bus_io.mem_rdata = mem_rdata_q;
   assign rom_addr_o       = bus_io.mem_addr;
   assign ram_wen_o        = ram_wen_q;
   assign ram_addr_o       = ram_addr_q;
   assign ram_wdata_o      = ram_wdata_q;
   assign leds_o           = leds_q;
   assign bus_err_o        = bus_err_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl with ROM/RAM models and a scoreboard of expected read data and latency.
module tb_mem_bus_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [31:0] rom_addr;
   logic [31:0] rom_data;
   logic [3:0]  ram_wen;
   logic [21:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;
   logic [7:0]  leds;
   logic        bus_err;

   mem_bus_ctrl_if bus_if();

   mem_bus_ctrl dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .bus_io      (bus_if.slave),
      .rom_addr_o  (rom_addr),
      .rom_data_i  (rom_data),
      .ram_wen_o   (ram_wen),
      .ram_addr_o  (ram_addr),
      .ram_wdata_o (ram_wdata),
      .ram_rdata_i (ram_rdata),
      .leds_o      (leds),
      .bus_err_o   (bus_err)
   );

   logic [31:0] rom_mem [256] = '{0: 32'h1111_2222, 2: 32'h00A0_0093, default: 32'h0};
   logic [31:0] ram_mem [256] = '{default: 32'h0};

   assign rom_data = rom_mem[rom_addr[9:2]];

   // Registered-read RAM with byte enables; reads return the word before the write.
   always @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (ram_wen[b]) ram_mem[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
      ram_rdata <= ram_mem[ram_addr[7:0]];
   end

   int          wen_cnt = 0;
   logic [3:0]  last_wen = '0;
   logic [21:0] last_waddr = '0;
   always @(negedge clk) begin
      if (ram_wen != 4'b0) begin
         wen_cnt++;
         last_wen   = ram_wen;
         last_waddr = ram_addr;
      end
   end

   typedef struct {
      logic [31:0] rdata;
      int          lat;
   } exp_t;
   exp_t sb[$];

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic req(input string tag, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] ws, input bit drop,
                      input logic [31:0] exp_rd, input int exp_lat);
      exp_t e;
      int   lat;
      bit   got;
      logic [31:0] obs;
      sb.push_back('{rdata: exp_rd, lat: exp_lat});
      @(negedge clk);
      bus_if.mem_valid = 1'b1;
      bus_if.mem_addr  = a;
      bus_if.mem_wdata = wd;
      bus_if.mem_wstrb = ws;
      @(posedge clk);
      got = 1'b0;
      lat = 0;
      obs = '0;
      for (int n = 1; n <= 8 && !got; n++) begin
         @(negedge clk);
         if (bus_if.mem_ready) begin
            got = 1'b1;
            lat = n;
            obs = bus_if.mem_rdata;
         end
         if (drop) bus_if.mem_valid = 1'b0;
      end
      bus_if.mem_valid = 1'b0;
      bus_if.mem_wstrb = 4'b0;
      e = sb.pop_front();
      check({tag, "_ready_seen"}, 32'(got), 32'd1);
      check({tag, "_rdata"}, obs, e.rdata);
      check({tag, "_latency"}, 32'(lat), 32'(e.lat));
      @(negedge clk);
      check({tag, "_pulse_width"}, 32'(bus_if.mem_ready), 32'd0);
   endtask

   int base;
   int ready_cnt;

   initial begin
      rst_n            = 1'b0;
      bus_if.mem_valid = 1'b0;
      bus_if.mem_addr  = '0;
      bus_if.mem_wdata = '0;
      bus_if.mem_wstrb = '0;
      repeat (2) @(negedge clk);
      check("rst_ready",  32'(bus_if.mem_ready), 32'd0);
      check("rst_rdata",  bus_if.mem_rdata, 32'd0);
      check("rst_wen",    32'(ram_wen), 32'd0);
      check("rst_waddr",  32'(ram_addr), 32'd0);
      check("rst_wdata",  ram_wdata, 32'd0);
      check("rst_leds",   32'(leds), 32'd0);
      check("rst_buserr", 32'(bus_err), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      base = wen_cnt;
      req("rom_rd8", 32'h0000_0008, 32'h0, 4'h0, 1'b0, 32'h00A0_0093, 1);
      check("rom_no_wen", 32'(wen_cnt - base), 32'd0);

      base = wen_cnt;
      req("ram_wr", 32'h0001_0004, 32'hCAFE_BABE, 4'b0011, 1'b0, 32'h0, 3);
      check("ram_wen_cycles", 32'(wen_cnt - base), 32'd1);
      check("ram_wen_val",    32'(last_wen), 32'h3);
      check("ram_wen_addr",   32'(last_waddr), 32'd1);
      req("ram_rd", 32'h0001_0004, 32'h0, 4'h0, 1'b0, 32'h0000_BABE, 3);

      req("led_wr", 32'h0002_0000, 32'h0000_005A, 4'b0001, 1'b0, 32'h0, 1);
      check("led_value", 32'(leds), 32'h5A);
      req("led_rd", 32'h0002_0000, 32'h0, 4'h0, 1'b0, 32'h0000_005A, 1);
      check("led_no_err", 32'(bus_err), 32'd0);

      req("unmapped_rd", 32'h0001_0400, 32'h0, 4'h0, 1'b0, 32'h0, 1);
      check("err_set", 32'(bus_err), 32'd1);
      req("rom_rd0", 32'h0000_0000, 32'h0, 4'h0, 1'b0, 32'h1111_2222, 1);
      check("err_sticky", 32'(bus_err), 32'd1);
      req("rom_end_unmapped", 32'h0000_0400, 32'h0, 4'h0, 1'b0, 32'h0, 1);

      req("ram_last_wr", 32'h0001_03FC, 32'h1234_5678, 4'hF, 1'b0, 32'h0, 3);
      req("ram_drop_rd", 32'h0001_03FC, 32'h0, 4'h0, 1'b1, 32'h1234_5678, 3);
      req("post_drop_rom", 32'h0000_0008, 32'h0, 4'h0, 1'b0, 32'h00A0_0093, 1);
      check("err_still_set", 32'(bus_err), 32'd1);

      // Reset while the RAM write enable is live.
      base = wen_cnt;
      @(negedge clk);
      bus_if.mem_valid = 1'b1;
      bus_if.mem_addr  = 32'h0001_0008;
      bus_if.mem_wdata = 32'hFFFF_FFFF;
      bus_if.mem_wstrb = 4'hF;
      @(posedge clk);
      #2;
      check("midrst_wen_live", 32'(ram_wen), 32'hF);
      rst_n = 1'b0;
      #1;
      check("midrst_wen",    32'(ram_wen), 32'd0);
      check("midrst_ready",  32'(bus_if.mem_ready), 32'd0);
      check("midrst_rdata",  bus_if.mem_rdata, 32'd0);
      check("midrst_waddr",  32'(ram_addr), 32'd0);
      check("midrst_wdata",  ram_wdata, 32'd0);
      check("midrst_leds",   32'(leds), 32'd0);
      check("midrst_buserr", 32'(bus_err), 32'd0);
      bus_if.mem_valid = 1'b0;
      bus_if.mem_wstrb = 4'h0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      ready_cnt = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus_if.mem_ready) ready_cnt++;
      end
      check("midrst_no_ready", 32'(ready_cnt), 32'd0);
      check("midrst_ram_word", ram_mem[2], 32'h0);
      check("midrst_no_wen",   32'(wen_cnt - base), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
